fetch_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_skid.sv | 43 ++++
 rtl/fetch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU front end (fetch sequencer).
package cpu_pkg;

    localparam int unsigned     XLEN       = 32;
    localparam logic [XLEN-1:0] INST_BYTES = 32'd4;
    localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK = INST_BYTES - 32'd1;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

    // Clear the sub-word offset bits of a byte address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

    // True when a byte address is not on an instruction boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry pc/instruction holding buffer that catches the
// response which arrives while decode is stalled.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic [XLEN-1:0] load_inst_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic            full_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o
);

    logic            full_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;

    // Flush beats load beats pop; data only changes on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            pc_q   <= '0;
            inst_q <= '0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
            pc_q   <= load_pc_i;
            inst_q <= load_inst_i;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, drives the synchronous
// instruction memory and hands pc/instruction pairs to decode over valid/ready.
// rst is asynchronous and active-low.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect raises
// fetch_fault and halts instead of silently word-aligning the target).
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    input  logic [XLEN-1:0] inst_rdata,
    output logic [XLEN-1:0] inst_addr,
    output logic            inst_ce,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic            halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            infl_q;
    logic [XLEN-1:0] infl_pc_q;

    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_inst_q, if_inst_d;

    logic            skid_full, skid_load, skid_pop;
    logic [XLEN-1:0] skid_pc, skid_inst;

    logic            stall, issue, pc_in_range, redir_in_range;
    logic [XLEN-1:0] redir_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            redir_misalign;
    logic            fault_q;
`endif

    // Issue and redirect-target decode.
    // Issue is allowed while the skid is being drained this cycle: the new
    // response lands in the slot that frees, so a stall release has no bubble.
    // Issue is blocked when an unconsumed output plus a pending response would
    // leave nowhere for a further response to go.
    always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
        redir_tgt      = redirect_pc;
        redir_misalign = is_misaligned(redirect_pc);
`else
        redir_tgt      = word_align(redirect_pc);
`endif
        redir_in_range = (redir_tgt < IMEM_BYTES);
        pc_in_range    = (pc_q < IMEM_BYTES);
        stall          = if_valid_q && !id_ready;
        issue          = (state_q == RUN) && pc_in_range && !redirect_valid
                         && (!stall || (!skid_full && !infl_q));
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redir_tgt;
        end else if (issue) begin
            pc_d = pc_q + INST_BYTES;
        end
    end

    // Sequencer FSM, program counter, in-flight tracking and fault flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            pc_q   <= pc_d;
            infl_q <= issue;
            if (issue) begin
                infl_pc_q <= pc_q;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_valid && redir_misalign) begin
                fault_q <= 1'b1;
                state_q <= HALT;
            end else
`endif
            if (redirect_valid) begin
                if (state_q != HALT || redir_in_range) begin
                    state_q <= RUN;
                end
            end else begin
                case (state_q)
                    BOOT:    state_q <= RUN;
                    RUN:     if (!pc_in_range) state_q <= HALT;
                    HALT:    state_q <= HALT;
                    default: state_q <= BOOT;
                endcase
            end
        end
    end

    // Output register steering: skid entry first, then the memory response.
    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        if (redirect_valid) begin
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
        end else if (!stall) begin
            if (skid_full) begin
                skid_pop   = 1'b1;
                if_valid_d = 1'b1;
                if_pc_d    = skid_pc;
                if_inst_d  = skid_inst;
            end else if (infl_q) begin
                if_valid_d = 1'b1;
                if_pc_d    = infl_pc_q;
                if_inst_d  = inst_rdata;
            end else begin
                if_valid_d = 1'b0;
            end
        end else if (infl_q) begin
            skid_load = 1'b1;
        end
    end

    // Output register toward decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else begin
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    fetch_skid u_skid (
        .clk         (clk),
        .rst_n       (rst),
        .load_i      (skid_load),
        .load_pc_i   (infl_pc_q),
        .load_inst_i (inst_rdata),
        .pop_i       (skid_pop),
        .flush_i     (redirect_valid),
        .full_o      (skid_full),
        .pc_o        (skid_pc),
        .inst_o      (skid_inst)
    );

    assign inst_addr = pc_q;
    assign inst_ce   = issue;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;
    assign halted    = (state_q == HALT);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table vectors, hand sequences and random traffic for fetch_ctrl,
// all cross-checked against a queue-based reference model of the fetch path.
module tb_fetch_ctrl;

    localparam logic [31:0] IMEM = 32'd1024;
    localparam int MB = 0, MR = 1, MH = 2;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic [31:0] inst_rdata;
    logic [31:0] inst_addr;
    logic        inst_ce;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
    bit          m_fault;
`endif

    int n_vec, n_err;

    // Reference model: mode, pc, fetched-but-undelivered queue, one pending read.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          exp_ce;

    fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (1024)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .inst_rdata     (inst_rdata),
        .inst_addr      (inst_addr),
        .inst_ce        (inst_ce),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .halted         (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: word index of the address.
    always @(posedge clk) begin
        if (inst_ce) inst_rdata <= inst_addr >> 2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MB;
        m_pc   = 32'h0;
        m_q.delete();
        m_pend = 1'b0;
        m_pend_pc = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
        m_fault = 1'b0;
`endif
    endtask

    // A read may start when the PC is in the window and, after decode takes
    // what it takes this cycle, at most one item remains held or pending.
    function automatic bit model_ce(input bit rv, input bit rdy);
        int occ;
        if (rv || m_mode != MR || m_pc >= IMEM) return 1'b0;
        occ = m_q.size() + (m_pend ? 1 : 0) - ((m_q.size() > 0 && rdy) ? 1 : 0);
        return occ <= 1;
    endfunction

    task automatic model_step(input bit rv, input logic [31:0] rpc, input bit rdy, input bit ce);
        logic [31:0] tgt;
        if (rv) begin
            m_q.delete();
            m_pend = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt = rpc;
            if (rpc % 4 != 0) begin
                m_fault = 1'b1;
                m_mode  = MH;
            end else if (!(m_mode == MH && tgt >= IMEM)) begin
                m_mode = MR;
            end
`else
            tgt = rpc - (rpc % 4);
            if (!(m_mode == MH && tgt >= IMEM)) m_mode = MR;
`endif
            m_pc = tgt;
        end else begin
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_pc);
            if (m_mode == MB) m_mode = MR;
            else if (m_mode == MR && m_pc >= IMEM) m_mode = MH;
            m_pend = ce;
            if (ce) begin
                m_pend_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Apply inputs (called at posedge+1) and compare against the model mid-cycle.
    task automatic drive(input bit rv, input logic [31:0] rpc, input bit rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(negedge clk);
        exp_ce = model_ce(rv, rdy);
        chk("inst_ce", inst_ce, exp_ce);
        chk("inst_addr", inst_addr, m_pc);
        chk("if_valid", if_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("if_pc", if_pc, m_q[0]);
            chk("if_inst", if_inst, m_q[0] >> 2);
        end
        chk("halted", halted, m_mode == MH);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("fetch_fault", fetch_fault, m_fault);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        model_step(redirect_valid, redirect_pc, id_ready, exp_ce);
        #1;
    endtask

    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        drive(rv, rpc, rdy);
        advance();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_valid"}, if_valid, 0);
        chk({tag, "_if_pc"}, if_pc, 0);
        chk({tag, "_if_inst"}, if_inst, 0);
        chk({tag, "_inst_ce"}, inst_ce, 0);
        chk({tag, "_inst_addr"}, inst_addr, 32'h0);
        chk({tag, "_halted"}, halted, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk({tag, "_fetch_fault"}, fetch_fault, 0);
`endif
    endtask

    typedef struct {
        bit          rv;
        logic [31:0] rpc;
        bit          rdy;
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_ce;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[16];
    bit   found;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b0;
        inst_rdata = 32'h0;

        // Cycle c0 is the BOOT cycle after release; stall at if_pc=8 for three
        // cycles, then a redirect to 0x40 while stalled with a read in flight.
        tbl[0]  = '{0, 32'h0,  1, 0, 32'h0,  0, 32'h0};
        tbl[1]  = '{0, 32'h0,  1, 0, 32'h0,  1, 32'h0};
        tbl[2]  = '{0, 32'h0,  1, 0, 32'h0,  1, 32'h4};
        tbl[3]  = '{0, 32'h0,  1, 1, 32'h0,  1, 32'h8};
        tbl[4]  = '{0, 32'h0,  1, 1, 32'h4,  1, 32'hC};
        tbl[5]  = '{0, 32'h0,  0, 1, 32'h8,  0, 32'h10};
        tbl[6]  = '{0, 32'h0,  0, 1, 32'h8,  0, 32'h10};
        tbl[7]  = '{0, 32'h0,  0, 1, 32'h8,  0, 32'h10};
        tbl[8]  = '{0, 32'h0,  1, 1, 32'h8,  1, 32'h10};
        tbl[9]  = '{0, 32'h0,  1, 1, 32'hC,  1, 32'h14};
        tbl[10] = '{0, 32'h0,  1, 1, 32'h10, 1, 32'h18};
        tbl[11] = '{0, 32'h0,  1, 1, 32'h14, 1, 32'h1C};
        tbl[12] = '{1, 32'h40, 0, 1, 32'h18, 0, 32'h20};
        tbl[13] = '{0, 32'h0,  1, 0, 32'h0,  1, 32'h40};
        tbl[14] = '{0, 32'h0,  1, 0, 32'h0,  1, 32'h44};
        tbl[15] = '{0, 32'h0,  1, 1, 32'h40, 1, 32'h48};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        model_reset();
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            chk("tbl_if_valid", if_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) chk("tbl_if_pc", if_pc, tbl[i].e_pc);
            chk("tbl_inst_ce", inst_ce, tbl[i].e_ce);
            chk("tbl_inst_addr", inst_addr, tbl[i].e_addr);
            advance();
        end

        // Run off the end of the instruction window, then resume via redirect.
        step(1'b1, 32'h3F0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive(1'b0, 32'h0, 1'b1);
            if (if_valid && if_pc == 32'h3FC) begin
                found = 1'b1;
                chk("halt_on_last", halted, 1);
                chk("halt_ce_on_last", inst_ce, 0);
            end
            advance();
        end
        chk("halt_reached", found, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1);
            chk("halt_ce_idle", inst_ce, 0);
            chk("halt_sticky", halted, 1);
            advance();
        end
        step(1'b1, 32'h100, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        chk("resume_valid", if_valid, 1);
        chk("resume_pc", if_pc, 32'h100);
        chk("resume_halted", halted, 0);
        advance();

        // Misaligned redirect target.
        step(1'b1, 32'h42, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        drive(1'b0, 32'h0, 1'b1);
        chk("misalign_fault", fetch_fault, 1);
        chk("misalign_halted", halted, 1);
        advance();
        step(1'b1, 32'h0, 1'b1);
`else
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        chk("misalign_valid", if_valid, 1);
        chk("misalign_pc", if_pc, 32'h40);
        advance();
`endif

        // Fill the skid under a stall, then reset asynchronously mid-cycle.
        repeat (4) step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        chk("skid_full_ce", inst_ce, 0);
        chk("skid_full_valid", if_valid, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) step(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        chk("restart_valid", if_valid, 1);
        chk("restart_pc", if_pc, 32'h0);
        advance();

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            bit          rv, rdy;
            logic [31:0] rpc;
            int unsigned k;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            k   = $urandom_range(0, 9);
            if (k < 6)       rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            else if (k < 8)  rpc = 32'h3E0 + 32'($urandom_range(0, 7)) * 4;
            else if (k == 8) rpc = ($urandom_range(0, 1) == 0) ? 32'h400 : 32'hFFFF_FFFC;
            else             rpc = 32'($urandom_range(0, 1023));
            step(rv, rpc, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
